// File: rtl/addsub_cla_pipe.sv
// Pipelined WIDTH-bit carry-lookahead add/sub, one SEG-bit slice per stage; ovf is live only with ADDSUB_CLA_OVF_EN.
// Latency: N = WIDTH/SEG cycles from acceptance to out_valid, plus one per stall cycle.
// Backpressure: whole pipe advances together; in_ready = !out_valid || out_ready.
module addsub_cla_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin,
  input  logic             din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N = WIDTH / SEG;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Every carry is a flat sum-of-products of g/p terms, not a ripple chain.
  function automatic logic [SEG:0] cla_carry(input logic [SEG-1:0] g,
                                             input logic [SEG-1:0] p,
                                             input logic           c0);
    logic [SEG:0] c;
    logic         term;
    c    = '0;
    c[0] = c0;
    for (int i = 1; i <= SEG; i++) begin
      term = c0;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  genvar k;
  for (k = 0; k < N; k++) begin : g_stg
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]    op_a, op_b;
    logic              op_c, v_d;
    logic [SEG-1:0]    g, p, sl_s;
    logic [SEG:0]      sl_c;
    logic [LO+SEG-1:0] s_d, s_q;
    logic              c_q, v_q;

    if (k == 0) begin : g_head
      assign op_a = ain;
      assign op_b = din ? bin : ~bin;
      assign op_c = din ? cin : 1'b1;
      assign v_d  = in_valid;
      assign s_d  = sl_s;
    end else begin : g_body
      assign op_a = g_fwd[k-1].a_q;
      assign op_b = g_fwd[k-1].b_q;
      assign op_c = g_stg[k-1].c_q;
      assign v_d  = g_stg[k-1].v_q;
      assign s_d  = {sl_s, g_stg[k-1].s_q};
    end

    assign g    = op_a[SEG-1:0] & op_b[SEG-1:0];
    assign p    = op_a[SEG-1:0] ^ op_b[SEG-1:0];
    assign sl_c = cla_carry(g, p, op_c);
    assign sl_s = p ^ sl_c[SEG-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_d;
        c_q <= sl_c[SEG];
        s_q <= s_d;
      end
    end
  end

  // Operand skew: upper slices not yet summed travel alongside the partial sum.
  for (k = 0; k < N - 1; k++) begin : g_fwd
    logic [WIDTH-(k+1)*SEG-1:0] a_q, b_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
      end else if (adv) begin
        a_q <= g_stg[k].op_a[WIDTH-k*SEG-1:SEG];
        b_q <= g_stg[k].op_b[WIDTH-k*SEG-1:SEG];
      end
    end
  end

  assign out_valid = g_stg[N-1].v_q;
  assign sum       = g_stg[N-1].s_q;
  assign cout      = g_stg[N-1].c_q;

`ifdef ADDSUB_CLA_OVF_EN
  logic cmsb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmsb_q <= 1'b0;
    end else if (adv) begin
      cmsb_q <= g_stg[N-1].sl_c[SEG-1];
    end
  end

  assign ovf = cmsb_q ^ cout;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_cla_pipe.sv
// Bench for addsub_cla_pipe: arithmetic reference model with in-order scoreboard plus literal result checks.
module tb_addsub_cla_pipe;

  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;
`ifdef ADDSUB_CLA_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk, rst_n, in_valid, in_ready, cin, din, out_valid, out_ready, cout, ovf;
  logic [W-1:0] ain, bin, sum;

  addsub_cla_pipe #(.WIDTH(W), .SEG(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ain(ain), .bin(bin), .cin(cin), .din(din),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t exp_q[$];
  res_t e;
  int   checks = 0;
  int   failures = 0;
  int   n_push = 0;
  int   n_pop = 0;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic d);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = d ? b : ~b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (d ? c : 1'b1)};
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.o  = OVF_ON && (a[W-1] == bb[W-1]) && (r.s[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid) begin
        chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          chk("sb_sum", 64'(sum), 64'(e.s));
          chk("sb_cout", 64'(cout), 64'(e.c));
          chk("sb_ovf", 64'(ovf), 64'(e.o));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ain, bin, cin, din));
        n_push++;
      end
    end
  end

  task automatic chk_out(input string nm, input logic [W-1:0] es, input logic ec, input logic eo);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_sum"}, 64'(sum), 64'(es));
    chk({nm, "_cout"}, 64'(cout), 64'(ec));
    chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, "_sum"}, 64'(sum), 64'd0);
    chk({nm, "_cout"}, 64'(cout), 64'd0);
    chk({nm, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  // Single beat with out_ready=1: result must appear exactly N edges after acceptance.
  task automatic lit_beat(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic d,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    ain = a; bin = b; cin = c; din = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < N - 2; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk_out(nm, es, ec, eo);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int w;
    w = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, cyc, pop0;
    logic took;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ain = '0; bin = '0; cin = 1'b0; din = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    lit_beat("add_carry16", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0);
    lit_beat("ripple_add", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0);
    lit_beat("sub_zero", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    lit_beat("ovf_pos", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, OVF_ON);
    lit_beat("ovf_neg", 32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, OVF_ON);

    // Back-to-back subtracts: borrow then no borrow.
    ain = 32'd5; bin = 32'd7; cin = 1'b1; din = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    ain = 32'd7; bin = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < N - 2; i++) begin
      @(posedge clk); #1;
    end
    chk_out("sub_5m7", 32'hFFFFFFFE, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_out("sub_7m5", 32'h00000002, 1'b1, 1'b0);
    @(posedge clk); #1;

    // 8 random beats with out_ready toggling every cycle.
    pop0 = n_pop; acc = 0; cyc = 0;
    ain = $urandom(); bin = $urandom(); cin = 1'($urandom_range(0, 1)); din = 1'($urandom_range(0, 1));
    while (acc < 8 && cyc < 100) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = 1'b1;
      #1;
      took = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (took) begin
        acc++;
        ain = $urandom(); bin = $urandom();
        cin = 1'($urandom_range(0, 1)); din = 1'($urandom_range(0, 1));
      end
    end
    chk("bp_accepted", 64'(acc), 64'd8);
    drain("bp");
    chk("bp_count", 64'(n_pop - pop0), 64'd8);

    // Random traffic with random stalls.
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      ain = $urandom(); bin = $urandom();
      if (c % 7 == 0) ain = 32'h7FFFFFFF;
      if (c % 11 == 0) bin = 32'h80000000;
      cin = 1'($urandom_range(0, 1)); din = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drain("rand");
    chk("rand_balance", 64'(n_push - n_pop), 64'd0);

    // Reset with three beats in flight.
    out_ready = 1'b1; din = 1'b1; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ain = 32'h100 + 32'(i); bin = 32'h10; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_idle("mid_rst");
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_stale", 64'(out_valid), 64'd0);
    end
    lit_beat("post_rst", 32'd1, 32'd2, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0);
    drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_cla_pipe.md
# addsub_cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the Booth multiplier datapath. It generalises the fixed-width add/sub cell to WIDTH bits, splitting the carry chain into SEG-bit lookahead slices with one register stage per slice. It sustains one operation per cycle behind a valid/ready handshake. It sits between the partial-product selector and the accumulator register.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of SEG.
- SEG, 8: slice width in bits. Pipeline depth is N = WIDTH/SEG stages; N ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low; one clock domain.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- ain  input  WIDTH  operand A.
- bin  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when din=1.
- din  input  1  mode: 1 = add (A+B+cin), 0 = subtract (A−B, i.e. A+~B+1, cin ignored).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB; in subtract mode, 1 means no borrow.
- ovf  output  1  two's-complement overflow (see Configuration).

## Operation
- Acceptance: a beat is accepted on a rising edge where in_valid && in_ready. A result is consumed where out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready; in_ready = adv. When adv=0, every stage holds its contents.
- Stage k (0..N−1) computes slice bits [k*SEG +: SEG] with full SEG-bit generate/propagate lookahead.
  - Its carry-in is the registered carry-out of stage k−1.
  - Stage 0 carry-in is din ? cin : 1.
  - B is conditionally inverted (~bin when din=0) at acceptance.
- Operand skew: stage k keeps the not-yet-consumed upper operand slices in registers. Stage k's sum slice is carried forward, so all N slices are aligned at the output.
- Each stage has a valid bit.
  - When adv=1, valid[0] <= in_valid, and valid[k] <= valid[k−1] for k ≥ 1.
  - Bubbles propagate; no beat is lost or duplicated.
- Output: out_valid = valid[N−1]. sum, cout and ovf are taken from the last stage registers.
- cout = carry out of bit WIDTH−1. The carry into bit WIDTH−1 is also retained for ovf.
- Data registers of invalid stages may hold stale data. sum, cout and ovf are only meaningful while out_valid=1.

## Timing
- Latency: a beat accepted at edge t presents out_valid=1 after edge t+N−1, i.e. N cycles with no stall. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready=1.
- in_ready is combinational from out_ready and out_valid; there is no combinational path from in_valid to any output.
- Reset (rst_n low, any time including mid-flight):
  - all valid bits clear immediately: out_valid=0, in_ready=1;
  - sum=0, cout=0, ovf=0, and all internal carries/data are 0;
  - in-flight beats are discarded; the first beat accepted after rst_n rises emerges N cycles later.
- Simultaneous accept and consume with a full pipe: allowed; the pipe shifts and occupancy is unchanged.
- N=1 (SEG=WIDTH): single registered stage with the same handshake rules.

## Configuration
- ADDSUB_CLA_OVF_EN: when defined, ovf = carry_into_MSB XOR cout, registered with the result.
- When undefined, the ovf port remains and is tied to 0, and the MSB carry-in register is not built.

## Test plan
- WIDTH=32, SEG=8 (N=4), out_ready=1: add 0x0000FFFF + 0x00000001, cin=0, din=1 → 4 cycles later sum=0x00010000, cout=0.
- Full carry ripple: 0xFFFFFFFF + 0x00000000, cin=1, din=1 → sum=0x00000000, cout=1. With din=0, 0xFFFFFFFF − 0 → sum=0xFFFFFFFF, cout=1, and cin is ignored.
- Subtract, with both cases back-to-back: 5 − 7 → sum=0xFFFFFFFE, cout=0; 7 − 5 → sum=0x00000002, cout=1.
- Overflow: 0x7FFFFFFF + 1 → sum=0x80000000, ovf=1 with ADDSUB_CLA_OVF_EN, ovf=0 without it; 0x80000000 − 1 → 0x7FFFFFFF, ovf=1 with the macro.
- Backpressure: 8 consecutive random beats with out_ready toggling 1,0,1,0 → results match a reference model in order; in_ready=0 exactly when out_valid=1 and out_ready=0; no drops or duplicates.
- Reset mid-flight: 3 beats in flight, pulse rst_n low for half a cycle → out_valid drops immediately with outputs 0; no stale beat emerges; a new beat 1+2 after reset yields 3 after 4 cycles.
